// File: rtl/modexp_pkg.sv
// Shared definitions for the ModExp host sequencer: operand geometry, ModExp
// state codes, and the sequencer's state and registered-control types.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package modexp_pkg;

  localparam int WIDTH      = 4096;
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int WORDS      = WIDTH / DATA_WIDTH;
  localparam int IDX_W      = $clog2(WORDS);
  localparam int CNT_W      = IDX_W + 1;
  localparam int INV_W      = 64;
  localparam int EXP_W      = 5;
  localparam int WDOG_W     = 24;

  // Operand slots streamed into ModExp, in m/e/n/r/t order.
  localparam int NUM_OPS = 5;
  localparam int OP_M    = 0;
  localparam int OP_E    = 1;
  localparam int OP_N    = 2;
  localparam int OP_R    = 3;
  localparam int OP_T    = 4;

  typedef enum logic [EXP_W-1:0] {
    INIT_STATE   = 5'd0,
    LOAD_INPUT   = 5'd1,
    PRECOMPUTE   = 5'd2,
    TO_MONT      = 5'd3,
    SCAN_EXP     = 5'd4,
    SQUARE       = 5'd5,
    MULTIPLY     = 5'd6,
    FROM_MONT    = 5'd7,
    STORE_RESULT = 5'd8,
    COMPLETE     = 5'd9,
    TERMINAL     = 5'd10
  } exp_state_e;

  localparam logic [EXP_W-1:0] EXP_COMPLETE = COMPLETE;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CALC_R   = 3'd1,
    S_CALC_T   = 3'd2,
    S_CALC_N0  = 3'd3,
    S_SEND     = 3'd4,
    S_WAIT_EXP = 3'd5,
    S_READ     = 3'd6,
    S_DONE     = 3'd7
  } seq_state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic rt_go;
    logic rt_mode;
    logic inv_go;
    logic start_input;
    logic start_compute;
    logic get_result;
  } seq_ctl_t;

endpackage

// File: rtl/modexp_host_sequencer_if.sv
// Signal bundle between the host/rtMod/modInv/ModExp side and the sequencer.
// Optional timeout_err exists only when MODEXP_SEQ_TIMEOUT_EN is defined.
interface modexp_host_sequencer_if;
  import modexp_pkg::*;

  // Handshakes: start is a one-cycle request honoured only in IDLE (busy=0) and
  // never queued; rt_go/inv_go are one-cycle pulses whose rt_done/inv_valid
  // completions count only from the cycle after the pulse; done is a one-cycle
  // pulse and result stays valid until the next accepted start.
  logic                  start;
  logic [WIDTH-1:0]      message;
  logic [WIDTH-1:0]      exponent;
  logic [WIDTH-1:0]      modulus;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      result;
  logic                  rt_go;
  logic                  rt_mode;
  logic [WIDTH-1:0]      rt_n;
  logic [WIDTH-1:0]      rt_r;
  logic                  rt_done;
  logic                  inv_go;
  logic [INV_W-1:0]      inv_val;
  logic                  inv_valid;
  logic [DATA_WIDTH-1:0] m_buf;
  logic [DATA_WIDTH-1:0] e_buf;
  logic [DATA_WIDTH-1:0] n_buf;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] t_buf;
  logic [INV_W-1:0]      nprime0;
  logic                  start_input;
  logic                  start_compute;
  logic                  get_result;
  logic [EXP_W-1:0]      exp_state;
  logic [DATA_WIDTH-1:0] res_out;
  seq_state_e            dbg_state;
`ifdef MODEXP_SEQ_TIMEOUT_EN
  logic                  timeout_err;
`endif

  modport slave (
    input  start, message, exponent, modulus, rt_r, rt_done, inv_val,
           inv_valid, exp_state, res_out,
    output busy, done, result, rt_go, rt_mode, rt_n, inv_go, m_buf, e_buf,
           n_buf, r_buf, t_buf, nprime0, start_input, start_compute,
           get_result, dbg_state
`ifdef MODEXP_SEQ_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport master (
    output start, message, exponent, modulus, rt_r, rt_done, inv_val,
           inv_valid, exp_state, res_out,
    input  busy, done, result, rt_go, rt_mode, rt_n, inv_go, m_buf, e_buf,
           n_buf, r_buf, t_buf, nprime0, start_input, start_compute,
           get_result, dbg_state
`ifdef MODEXP_SEQ_TIMEOUT_EN
    , input timeout_err
`endif
  );

endinterface

// File: rtl/word_slicer.sv
// Selects one DATA_WIDTH word out of a WIDTH-bit operand register.
module word_slicer
  import modexp_pkg::*;
(
  input  logic [WIDTH-1:0]      data_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [WORDS-1:0][DATA_WIDTH-1:0] words;

  assign words  = data_i;
  assign word_o = words[idx_i];

endmodule

// File: rtl/modexp_host_sequencer.sv
// Sequences rtMod (R, T), modInv (nprime0), the word stream into ModExp and the
// result read-back. Define MODEXP_SEQ_TIMEOUT_EN to add a 24-bit wait watchdog.
module modexp_host_sequencer
  import modexp_pkg::*;
(
  input logic              clk,
  input logic              reset,
  modexp_host_sequencer_if.slave bus
);

  seq_state_e                       state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [NUM_OPS-1:0][WIDTH-1:0]    op_q, op_d;
  logic [NUM_OPS-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic [NUM_OPS-1:0][DATA_WIDTH-1:0] slice_w;
  logic [INV_W-1:0]                 nprime_q, nprime_d;
  logic [WORDS-1:0][DATA_WIDTH-1:0] result_q, result_d;
  seq_ctl_t                         ctl_q, ctl_d;
  logic [IDX_W-1:0]                 slice_idx;
  logic [IDX_W-1:0]                 rd_idx;

  // Buffers are registered, so the slicers look one word ahead of the counter.
  assign slice_idx = (state_q == S_SEND) ? cnt_q[IDX_W-1:0] + IDX_W'(1) : '0;
  // res_out lags by one cycle: read cycle c carries word c-1.
  assign rd_idx    = cnt_q[IDX_W-1:0] - IDX_W'(1);

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_slice
    word_slicer u_slice (
      .data_i (op_q[g]),
      .idx_i  (slice_idx),
      .word_o (slice_w[g])
    );
  end

`ifdef MODEXP_SEQ_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    buf_d         = buf_q;
    nprime_d      = nprime_q;
    result_d      = result_q;
    ctl_d         = ctl_q;
    ctl_d.rt_go   = 1'b0;
    ctl_d.inv_go  = 1'b0;
    ctl_d.done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d[OP_M]    = bus.message;
          op_d[OP_E]    = bus.exponent;
          op_d[OP_N]    = bus.modulus;
          op_d[OP_R]    = '0;
          op_d[OP_T]    = '0;
          result_d      = '0;
          ctl_d.busy    = 1'b1;
          ctl_d.rt_mode = 1'b0;
          ctl_d.rt_go   = 1'b1;
          state_d       = S_CALC_R;
        end
      end
      S_CALC_R: begin
        if (bus.rt_done && !ctl_q.rt_go) begin
          op_d[OP_R]    = bus.rt_r;
          ctl_d.rt_mode = 1'b1;
          ctl_d.rt_go   = 1'b1;
          state_d       = S_CALC_T;
        end
      end
      S_CALC_T: begin
        if (bus.rt_done && !ctl_q.rt_go) begin
          op_d[OP_T]   = bus.rt_r;
          ctl_d.inv_go = 1'b1;
          state_d      = S_CALC_N0;
        end
      end
      S_CALC_N0: begin
        if (bus.inv_valid && !ctl_q.inv_go) begin
          nprime_d          = bus.inv_val;
          cnt_d             = '0;
          buf_d             = slice_w;
          ctl_d.start_input = 1'b1;
          state_d           = S_SEND;
        end
      end
      S_SEND: begin
        if (cnt_q == CNT_W'(WORDS - 1)) begin
          cnt_d               = '0;
          ctl_d.start_input   = 1'b0;
          ctl_d.start_compute = 1'b1;
          ctl_d.get_result    = 1'b1;
          state_d             = S_WAIT_EXP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          buf_d = slice_w;
        end
      end
      S_WAIT_EXP: begin
        if (bus.exp_state == EXP_COMPLETE) begin
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q != '0) result_d[rd_idx] = bus.res_out;
        if (cnt_q == CNT_W'(WORDS)) begin
          ctl_d.done          = 1'b1;
          ctl_d.busy          = 1'b0;
          ctl_d.start_compute = 1'b0;
          ctl_d.get_result    = 1'b0;
          state_d             = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef MODEXP_SEQ_TIMEOUT_EN
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (state_q == S_IDLE && bus.start) timeout_d = 1'b0;
    if (state_d != state_q &&
        state_d inside {S_CALC_R, S_CALC_T, S_CALC_N0, S_WAIT_EXP}) begin
      wdog_d = '1;
    end else if (state_q inside {S_CALC_R, S_CALC_T, S_CALC_N0, S_WAIT_EXP}) begin
      if (wdog_q == '0) begin
        ctl_d     = '0;
        timeout_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        wdog_d = wdog_q - WDOG_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      buf_q    <= '0;
      nprime_q <= '0;
      result_q <= '0;
      ctl_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      buf_q    <= buf_d;
      nprime_q <= nprime_d;
      result_q <= result_d;
      ctl_q    <= ctl_d;
    end
  end

`ifdef MODEXP_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_err = timeout_q;
`endif

  assign bus.busy          = ctl_q.busy;
  assign bus.done          = ctl_q.done;
  assign bus.result        = result_q;
  assign bus.rt_go         = ctl_q.rt_go;
  assign bus.rt_mode       = ctl_q.rt_mode;
  assign bus.rt_n          = op_q[OP_N];
  assign bus.inv_go        = ctl_q.inv_go;
  assign bus.m_buf         = buf_q[OP_M];
  assign bus.e_buf         = buf_q[OP_E];
  assign bus.n_buf         = buf_q[OP_N];
  assign bus.r_buf         = buf_q[OP_R];
  assign bus.t_buf         = buf_q[OP_T];
  assign bus.nprime0       = nprime_q;
  assign bus.start_input   = ctl_q.start_input;
  assign bus.start_compute = ctl_q.start_compute;
  assign bus.get_result    = ctl_q.get_result;
  assign bus.dbg_state     = state_q;

endmodule

// File: doc/modexp_host_sequencer.md
# modexp_host_sequencer

Synthesizable controller between the 4096-bit host operand registers and the word-serial `ModExp` core. Per request it:
- runs `rtMod` twice: mode 0 produces R mod n, mode 1 produces T.
- runs `modInv` to obtain `nprime0`.
- streams m, e, n, r and t into `ModExp` 64 bits per cycle.
- waits for the core's COMPLETE state, then gathers the result words back into a 4096-bit register.

## Interface
Parameters:
- `WIDTH`, 4096, operand width in bits.
- `DATA_WIDTH`, 64, word width; equals `` `DATA_WIDTH ``.
- `WORDS`, WIDTH/DATA_WIDTH = 64, words per operand.
- `EXP_COMPLETE`, 9, `ModExp` `exp_state` code for COMPLETE.

Ports (reset is asynchronous and active-low):
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request pulse; ignored unless IDLE.
- `message`, `exponent`, `modulus`  in  WIDTH each  operands; sampled on the cycle `start` is accepted.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle.
- `result`  out  WIDTH  m^e mod n; held until the next accepted `start`.
- `rt_go`  out  1  one-cycle pulse to `rtMod`.
- `rt_mode`  out  1  0 selects R, 1 selects T.
- `rt_n`  out  WIDTH  latched modulus.
- `rt_r`  in  WIDTH  `rtMod` result.
- `rt_done`  in  1  `rtMod` completion.
- `inv_go`  out  1  one-cycle pulse to `modInv`.
- `inv_val`  in  64  `modInv` result.
- `inv_valid`  in  1  `modInv` completion.
- `m_buf`, `e_buf`, `n_buf`, `r_buf`, `t_buf`  out  DATA_WIDTH each  word stream into `ModExp`.
- `nprime0`  out  64  latched inverse.
- `start_input`, `start_compute`, `get_result`  out  1 each  `ModExp` controls.
- `exp_state`  in  5  `ModExp` state.
- `res_out`  in  DATA_WIDTH  `ModExp` result word.

## Operation
- **Reset.** Every output and internal register is 0 and the FSM is in IDLE.
- **IDLE.** On `start`: latch `message`, `exponent` and `modulus`; set `rt_mode`=0; pulse `rt_go`; go to CALC_R.
- **CALC_R.** On `rt_done`: latch `rt_r` into R; set `rt_mode`=1; pulse `rt_go`; go to CALC_T.
- **CALC_T.** On `rt_done`: latch `rt_r` into T; pulse `inv_go`; go to CALC_N0.
- **CALC_N0.** On `inv_valid`: latch `nprime0`; clear the word counter; go to SEND.
- **SEND.** Lasts exactly WORDS cycles.
  - `start_input`=1 throughout.
  - On cycle k, all five buffer outputs carry slice [k*DATA_WIDTH +: DATA_WIDTH] of their operands.
  - After word WORDS-1: `start_compute`=1, `get_result`=1, `start_input`=0; go to WAIT_EXP.
- **WAIT_EXP.** When `exp_state`==EXP_COMPLETE: clear the counter; go to READ.
- **READ.** Lasts WORDS+1 cycles because `res_out` lags by one cycle.
  - On read cycle c, for c=1..WORDS, capture `res_out` into `result` word c-1.
  - After the last capture go to DONE.
- **DONE.** Pulse `done`; drop `start_compute` and `get_result`; go to IDLE.
- The counter is $clog2(WORDS)+1 bits wide and never wraps within a phase.
- A `rt_done` or `inv_valid` arriving in the same cycle as the corresponding go pulse is ignored. The FSM acts only on completions from the cycle after go.
- `start` asserted while busy is dropped and is not queued.
- Asserting `reset` mid-operation aborts immediately. `result` clears and no `done` is issued.

## Timing
- Latency from `start` to `done` is 2 + t_rtR + t_rtT + t_inv + WORDS + t_exp + (WORDS+1) + 1 cycles.
- All outputs are registered; there is no combinational path from input to output.
- `busy` rises one cycle after `start` and falls in the cycle `done` pulses.

## Configuration
- `MODEXP_SEQ_TIMEOUT_EN` defined:
  - A 24-bit watchdog reloads on entry to CALC_R, CALC_T, CALC_N0 and WAIT_EXP.
  - On expiry the FSM returns to IDLE and sets the extra output `timeout_err` (1 bit).
  - `timeout_err` clears on the next accepted `start`; no `done` is issued.
- Undefined: the FSM waits indefinitely, and `timeout_err` is absent.

## Structure
- Shared package `modexp_pkg` holds:
  - the sequencer state enum;
  - the `ModExp` state codes (INIT_STATE..TERMINAL, COMPLETE=9);
  - WIDTH, DATA_WIDTH and WORDS.
- Sub-module `word_slicer`: combinational mux from a WIDTH-bit register to one word, driven by the counter. It is instantiated five times in SEND.

## Test plan
- **Nominal.** Stubs: `rtMod` R=0x11 and T=0x22 after 5 cycles; `modInv` returns 0xABCD after 3 cycles; `ModExp` reaches COMPLETE 20 cycles after `start_compute` and returns words 0..63 = index+1. Drive m=8, e=13, n=77 → `m_buf` word 0 = 8, `e_buf` = 13, `n_buf` = 77, `r_buf` = 0x11, `t_buf` = 0x22, `nprime0` = 0xABCD; `result` word k = k+1; `done` pulses once.
- **Word order.** Set m word k = k → `m_buf` equals 0..63 over exactly 64 cycles with `start_input`=1; `start_compute` rises the cycle after word 63.
- **Start while busy.** Pulse `start` during SEND → no effect on the stream; exactly one `done` is issued.
- **Reset during WAIT_EXP.** Assert reset → all outputs 0 in the same cycle; a following `start` completes normally.
- **Same-cycle completion.** Drive `rt_done` in the same cycle as `rt_go` → it is ignored; the FSM latches R only on a later `rt_done`.
- **Timeout (`MODEXP_SEQ_TIMEOUT_EN`).** Stub `modInv` never asserts `inv_valid` → `timeout_err`=1 after 2^24 cycles, FSM back in IDLE, no `done`.
